// File: rtl/cdc_hs_rx_ctrl.sv
// Destination (clkB) side of a toggle req/ack CDC handshake: synchronises req_tgl,
// captures the source-held bus, offers it with valid/ready, then toggles ack back.
module cdc_hs_rx_ctrl #(
  parameter int DATA_W        = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic              clkB,
  input  logic              rstB,
  input  logic              req_tgl,
  input  logic [DATA_W-1:0] data_in,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              ack_tgl,
  output logic              busy,
  output logic              proto_err,
  output logic [CNT_W-1:0]  xfer_cnt
);

  // Consumer handshake: a word transfers on any clkB edge where data_valid && out_ready;
  // data_valid never drops and data_out never changes until that edge.

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] VALID  = 2'd2;

  localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

  // Current FSM state; kept as a named signal so checkers can bind to it.
  logic [1:0]             state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_sync;
  logic                   req_prev;
  logic                   req_edge;
  logic [3:0]             settle_cnt;

  assign req_sync = sync_q[SYNC_STAGES-1];
  assign req_edge = req_sync ^ req_prev;
  assign busy     = (state != IDLE);

  always_ff @(posedge clkB) begin
    if (rstB) begin
      sync_q     <= '0;
      req_prev   <= 1'b0;
      state      <= IDLE;
      settle_cnt <= 4'd0;
      data_out   <= '0;
      data_valid <= 1'b0;
      ack_tgl    <= 1'b0;
      proto_err  <= 1'b0;
      xfer_cnt   <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], req_tgl};
      req_prev <= req_sync;

      // A new request while a transfer is in flight is dropped, only flagged.
      if (req_edge && (state != IDLE)) proto_err <= 1'b1;

      case (state)
        IDLE: begin
          if (req_edge) begin
            if (SETTLE_CYCLES > 0) begin
              state      <= SETTLE;
              settle_cnt <= SETTLE_LOAD;
            end else begin
              data_out   <= data_in;
              data_valid <= 1'b1;
              state      <= VALID;
            end
          end
        end
        SETTLE: begin
          if (settle_cnt == 4'd0) begin
            data_out   <= data_in;
            data_valid <= 1'b1;
            state      <= VALID;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        VALID: begin
          if (out_ready) begin
            data_valid <= 1'b0;
            ack_tgl    <= ~ack_tgl;
            xfer_cnt   <= xfer_cnt + 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cdc_hs_rx_ctrl.md
Name: cdc_hs_rx_ctrl

Overview:
- Destination-domain controller for a toggle-based request/acknowledge CDC handshake carrying a multi-bit bus.
- Synchronises the incoming request toggle through a flop chain and detects new requests.
- Sequences capture of the source-held data bus, presents it to a consumer with valid/ready, then returns an acknowledge toggle to the source domain.
- Sits on the clkB side of a clkA→clkB crossing; the source-side sender is a separate block.

Parameters:
- DATA_W, 8, width of the crossing data bus.
- SYNC_STAGES, 2, flops in the req_tgl synchroniser chain (legal 2..4).
- SETTLE_CYCLES, 1, extra clkB cycles between request detection and data capture (legal 0..15).
- CNT_W, 8, width of the completed-transfer counter.

Ports:
- clkB  input  1  destination-domain clock; all logic on its rising edge.
- rstB  input  1  synchronous, active-high reset.
- req_tgl  input  1  request toggle from the clkA domain (asynchronous to clkB).
- data_in  input  DATA_W  bus from the source, held stable by the source from its req toggle until it sees ack.
- out_ready  input  1  consumer ready.
- data_out  output  DATA_W  captured word.
- data_valid  output  1  data_out valid.
- ack_tgl  output  1  acknowledge toggle back to the source domain (registered).
- busy  output  1  FSM not in IDLE.
- proto_err  output  1  sticky: request edge seen while busy.
- xfer_cnt  output  CNT_W  completed handshakes, wrapping.

Behaviour:
- Reset (rstB=1 at a clkB edge):
  - All synchroniser flops, req_prev, data_out, data_valid, ack_tgl, proto_err and xfer_cnt go to 0.
  - FSM goes to IDLE; settle counter goes to 0.
  - Reset mid-transfer abandons the transfer with no ack. The source side must be reset alongside.
- Synchroniser and edge detect:
  - req_tgl passes through SYNC_STAGES flops; req_sync is the last stage.
  - req_prev <= req_sync every cycle.
  - req_edge = req_sync ^ req_prev, combinational.
- FSM states: IDLE, SETTLE, VALID.
- IDLE:
  - If req_edge and SETTLE_CYCLES>0: go to SETTLE and load the counter with SETTLE_CYCLES-1.
  - If req_edge and SETTLE_CYCLES=0: data_out <= data_in, data_valid <= 1, go to VALID.
- SETTLE:
  - If counter = 0: data_out <= data_in, data_valid <= 1, go to VALID.
  - Otherwise decrement the counter.
  - SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- VALID:
  - data_valid=1 and data_out held stable.
  - When out_ready=1: data_valid <= 0, ack_tgl <= ~ack_tgl, xfer_cnt <= xfer_cnt+1 (wraps 2^CNT_W-1→0), go to IDLE.
  - out_ready low holds VALID indefinitely.
- Latency:
  - First clkB edge sampling the new req_tgl level is E1.
  - data_valid rises after edge E(SYNC_STAGES+1+SETTLE_CYCLES); with defaults, after E4.
  - Ack toggles on the same edge that data_valid falls.
- Back-to-back requests:
  - After returning to IDLE, a new edge is accepted in the very next cycle; no dead cycle is required.
- Protocol error:
  - req_edge while in SETTLE or VALID sets proto_err (sticky until rstB).
  - The request is dropped, not queued; the current transfer continues unaffected.
  - The VALID→IDLE transition cycle counts as VALID for this check.
- busy = (state != IDLE).
- data_out is only updated at capture; outside VALID it holds the last captured value.

Test Plan (DATA_W=8, SYNC_STAGES=2, SETTLE_CYCLES=1, CNT_W=8):
- Reset: hold rstB 2 cycles with req_tgl=1 → after release data_valid=0, ack_tgl=0, xfer_cnt=0, proto_err=0; req_sync becomes 1 after 2 edges, so one transfer is then accepted (defined power-up behaviour; the source must also reset req_tgl to 0).
- Single transfer: data_in=0xA5, toggle req_tgl 0→1 before E1, out_ready=1 → data_valid rises after E4 with data_out=0xA5; ack_tgl 0→1 and data_valid=0 after E5; xfer_cnt=1.
- Backpressure: same as above with out_ready=0 for 10 cycles → data_valid and data_out=0xA5 held; no ack. Raise out_ready → ack toggles on the next edge.
- SETTLE_CYCLES=0 build: data_in=0x3C, toggle req → data_valid after E3 with 0x3C.
- Protocol error: toggle req twice, 2 cycles apart, during one transfer → one capture only, proto_err=1 sticky, xfer_cnt=1 after ack.
- Wrap and mid-reset: 256 back-to-back transfers → xfer_cnt returns to 0. Then assert rstB while in VALID → next cycle data_valid=0, ack_tgl=0, busy=0.
